// File: rtl/alu_32.sv
// 32-bit integer ALU: logic/add/sub/SLT core, zero and signed-overflow flags, sticky overflow status.
// Define ALU32_OUT_REG_EN to register Saida/Zero/Overflow (1-cycle latency).
module alu_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  F,
    output logic [31:0] Saida,
    output logic        Zero,
    output logic        Overflow,
    output logic        OverflowSticky
);

    typedef enum logic [2:0] {
        FN_AND  = 3'b000,
        FN_OR   = 3'b001,
        FN_ADD  = 3'b010,
        FN_RSVD = 3'b011,
        FN_ANDN = 3'b100,
        FN_ORN  = 3'b101,
        FN_SUB  = 3'b110,
        FN_SLT  = 3'b111
    } fn_t;

    fn_t         fn;
    logic [31:0] bx;
    logic [31:0] sum;
    logic        v_sum;
    logic [31:0] res_c;
    logic        zero_c;
    logic        ovf_c;

    assign fn = fn_t'(F);

    // One shared adder: F[2] selects ~B plus carry-in, covering both add and subtract.
    always_comb begin
        bx    = F[2] ? ~B : B;
        sum   = A + bx + 32'(F[2]);
        v_sum = (A[31] == bx[31]) && (sum[31] != A[31]);
    end

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        case (fn)
            FN_AND:  res_c = A & B;
            FN_OR:   res_c = A | B;
            FN_ADD:  begin
                res_c = sum;
                ovf_c = v_sum;
            end
            FN_RSVD: res_c = '0;
            FN_ANDN: res_c = A & ~B;
            FN_ORN:  res_c = A | ~B;
            FN_SUB:  begin
                res_c = sum;
                ovf_c = v_sum;
            end
            // Sign of the difference corrected by overflow gives the true signed less-than.
            FN_SLT:  res_c = {31'b0, sum[31] ^ v_sum};
            default: res_c = '0;
        endcase
        zero_c = ~|res_c;
    end

`ifdef ALU32_OUT_REG_EN
    logic [31:0] saida_r;
    logic        zero_r;
    logic        ovf_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            saida_r <= '0;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            saida_r <= res_c;
            zero_r  <= zero_c;
            ovf_r   <= ovf_c;
        end
    end

    assign Saida    = saida_r;
    assign Zero     = zero_r;
    assign Overflow = ovf_r;
`else
    assign Saida    = res_c;
    assign Zero     = zero_c;
    assign Overflow = ovf_c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            OverflowSticky <= 1'b0;
        end else begin
            OverflowSticky <= OverflowSticky | Overflow;
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Scoreboard bench for alu_32: directed vectors push expectations, a negedge monitor pops and compares.
module tb_alu_32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  F;
    logic [31:0] Saida;
    logic        Zero;
    logic        Overflow;
    logic        OverflowSticky;

    alu_32 dut (
        .clk            (clk),
        .reset          (reset),
        .A              (A),
        .B              (B),
        .F              (F),
        .Saida          (Saida),
        .Zero           (Zero),
        .Overflow       (Overflow),
        .OverflowSticky (OverflowSticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        bit          is_sticky;
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        st;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic sticky_m = 1'b0;
    logic ovfr_m   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one vector just after a rising edge and queue what the DUT must show.
    task automatic apply(input int id, input logic rst, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input logic z, input logic v);
        exp_t e;
        exp_t es;
        @(posedge clk);
        #2;
        reset = rst;
        F = f;
        A = a;
        B = b;
        e.id = id;
        e.is_sticky = 1'b0;
        e.st = 1'b0;
        es.id = id;
        es.is_sticky = 1'b1;
        es.s = '0;
        es.z = 1'b0;
        es.v = 1'b0;
        es.due = cyc + 1;
`ifdef ALU32_OUT_REG_EN
        e.due = cyc + 1;
        if (rst) begin
            e.s = '0;
            e.z = 1'b0;
            e.v = 1'b0;
        end else begin
            e.s = s;
            e.z = z;
            e.v = v;
        end
        sticky_m = rst ? 1'b0 : (sticky_m | ovfr_m);
        ovfr_m   = rst ? 1'b0 : v;
`else
        e.due = cyc;
        e.s = s;
        e.z = z;
        e.v = v;
        sticky_m = rst ? 1'b0 : (sticky_m | v);
`endif
        es.st = sticky_m;
        q.push_back(e);
        q.push_back(es);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL vec%0d late: due cycle %0d, now %0d", e.id, e.due, cyc);
            end else if (e.is_sticky) begin
                checks++;
                if (OverflowSticky !== e.st) begin
                    errors++;
                    $display("FAIL vec%0d OverflowSticky: got %b expected %b", e.id, OverflowSticky, e.st);
                end
            end else begin
                checks++;
                if (Saida !== e.s) begin
                    errors++;
                    $display("FAIL vec%0d Saida: got %h expected %h", e.id, Saida, e.s);
                end
                checks++;
                if (Zero !== e.z) begin
                    errors++;
                    $display("FAIL vec%0d Zero: got %b expected %b", e.id, Zero, e.z);
                end
                checks++;
                if (Overflow !== e.v) begin
                    errors++;
                    $display("FAIL vec%0d Overflow: got %b expected %b", e.id, Overflow, e.v);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        F = 3'b000;
        A = '0;
        B = '0;
        //    id rst F       A             B             Saida         Z     V
        apply(0,  1, 3'b000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        apply(1,  0, 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0);
        apply(2,  0, 3'b101, 32'hFFFF0000, 32'h0F0F0F0F, 32'hFFFFF0F0, 1'b0, 1'b0);
        apply(3,  0, 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        apply(4,  0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        apply(5,  0, 3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
        apply(6,  0, 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
        apply(7,  0, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        apply(8,  0, 3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0);
        apply(9,  1, 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        apply(10, 0, 3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0);
        apply(11, 0, 3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 32'hFFFF0F0F, 1'b0, 1'b0);
        apply(12, 0, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 1'b0, 1'b0);
        apply(13, 0, 3'b010, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0);
        apply(14, 0, 3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        apply(15, 0, 3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
        apply(16, 0, 3'b010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
        apply(17, 0, 3'b000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        apply(18, 1, 3'b001, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        apply(19, 0, 3'b000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_32.md
# alu_32

32-bit integer ALU for the single-cycle datapath: a combinational arithmetic/logic core driven by a 3-bit function code, producing the result, a zero flag and a signed-overflow flag. A clocked status register accumulates overflow events between resets. An optional output register stage, selected at compile time, retimes the result and flags by one cycle.

## Interface
- No parameters; width fixed at 32.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  32  operand A, two's complement.
- B  input  32  operand B, two's complement.
- F  input  3  function code.
- Saida  output  32  result.
- Zero  output  1  high when Saida == 0.
- Overflow  output  1  signed overflow of the current add/sub.
- OverflowSticky  output  1  registered; set by any Overflow, cleared only by reset.

## Operation
- Let Bx = F[2] ? ~B : B and Sum = A + Bx + F[2], computed mod 2^32.
- F=000: Saida = A & B.
- F=001: Saida = A | B.
- F=010: Saida = A + B.
- F=011: reserved; Saida = 0.
- F=100: Saida = A & ~B.
- F=101: Saida = A | ~B.
- F=110: Saida = A - B.
- F=111 (SLT): Saida = 32'h1 if A < B, signed; else 0. Computed as Sum[31] ^ V, where V is the subtract overflow, so the comparison is correct even when A - B overflows.
- Zero = ~|Saida, for every F including the reserved code.
- Overflow:
  - For F=010 and F=110 only: (A[31] == Bx[31]) && (Sum[31] != A[31]).
  - 0 for all other F, including SLT.
- Carry-out is not exported.
- OverflowSticky:
  - On each rising clk edge with reset=0: OverflowSticky <= OverflowSticky | Overflow, sampled from the Overflow output.
  - On a rising edge with reset=1: OverflowSticky <= 0, regardless of Overflow.

## Timing
- Default build: Saida, Zero and Overflow are purely combinational from A, B and F. Latency is 0 and they are independent of clk and reset.
- OverflowSticky updates one edge after the Overflow that sets it.
- OverflowSticky reset value is 0.
- No handshake; inputs are sampled continuously.
- Reset asserted mid-stream clears OverflowSticky at that edge only. The combinational outputs are unaffected.

## Configuration
- Macro ALU32_OUT_REG_EN.
- Defined: Saida, Zero and Overflow are registered on the rising edge of clk, giving 1-cycle latency from A/B/F.
  - Reset drives Saida=0, Zero=0, Overflow=0.
  - OverflowSticky then accumulates the registered Overflow, adding one further cycle of latency.
- Undefined: combinational outputs as in Operation. Only OverflowSticky uses clk and reset.

## Test plan
Default build unless stated.
- Logic ops:
  - F=000, A=FFFF0000, B=0F0F0F0F -> Saida=0F0F0000, Zero=0, Overflow=0.
  - F=101, same A and B -> Saida=FFFFF0F0, Zero=0, Overflow=0.
- Add:
  - F=010, A=7FFFFFFF, B=00000001 -> Saida=80000000, Overflow=1, Zero=0.
  - F=010, A=FFFFFFFF, B=00000001 -> Saida=0, Zero=1, Overflow=0.
- Subtract:
  - F=110, A=80000000, B=00000001 -> Saida=7FFFFFFF, Overflow=1.
  - F=110, A=00000005, B=00000005 -> Saida=0, Zero=1, Overflow=0.
- SLT:
  - F=111, A=FFFFFFFF, B=00000000 -> Saida=1, Overflow=0.
  - F=111, A=7FFFFFFF, B=80000000 -> Saida=0, Zero=1.
  - F=111, A=80000000, B=7FFFFFFF -> Saida=1.
- Reserved code: F=011, any A/B -> Saida=0, Zero=1, Overflow=0.
- Sticky flag:
  - reset=1 for one edge -> OverflowSticky=0.
  - Apply an overflowing add -> OverflowSticky=1 after the next edge, and it stays 1 through non-overflow operations.
  - reset=1 -> OverflowSticky=0 at the next edge.
- ALU32_OUT_REG_EN build:
  - Reset -> Saida=0, Zero=0, Overflow=0.
  - F=010, A=2, B=3 -> Saida=5 appears exactly one edge later.
